// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified instruction/data SRAM port arbiter.
// Contents:
//   resp_owner_e : which requester owns the read data returning this cycle
//   CSN_IDLE     : SRAM chip-select level when no access is issued
//   WEN_READ     : SRAM write-enable level for a read (or idle)
//   STREAK_W     : width of the consecutive contested-D-grant counter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } resp_owner_e;

  localparam logic CSN_IDLE = 1'b1;
  localparam logic WEN_READ = 1'b1;
  localparam int   STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_fairness_ctr.sv
// Fetch-starvation guard for the SRAM port arbiter.
// Counts consecutive data grants won while fetch was also requesting, and
// raises force_i_o once MAX_D_STREAK of them have happened in a row.
// Ports:
//   clk_i             clock, rising edge
//   rst_i             asynchronous active-high reset
//   i_req_i           fetch request
//   i_gnt_i           fetch granted this cycle
//   d_contested_gnt_i data granted this cycle while fetch was also requesting
//   force_i_o         fetch must win the next contested cycle
module arb_fairness_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_req_i,
  input  logic i_gnt_i,
  input  logic d_contested_gnt_i,
  output logic force_i_o
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  // The streak only matters while fetch is actually waiting, so any cycle
  // without a fetch request restarts it, as does fetch finally winning.
  always_comb begin
    streak_d = streak_q;
    if (!i_req_i || i_gnt_i) begin
      streak_d = '0;
    end else if (d_contested_gnt_i && (streak_q < MAX_STREAK)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_i_o = (streak_q >= MAX_STREAK);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port SRAM between the core's instruction
// fetch (I) and data access (D) requesters for a unified-memory build.
// Grants are combinational, one per cycle; read data returns from the SRAM
// one cycle later and is steered to whichever requester was granted.
// Ports:
//   CLK, RST                       clock and asynchronous active-high reset
//   I_REQ/I_ADDR -> I_GNT          fetch request / grant
//   I_RVALID/I_RDATA               fetch read response
//   D_REQ/D_WE/D_BE/D_ADDR/D_WDATA data request (read or byte-masked write)
//   D_GNT                          data grant
//   D_RVALID/D_RDATA               data read response
//   M_CSN/M_WEN/M_BE/M_ADDR/M_DI   SRAM strobes, word address, write data
//   M_DOUT                         SRAM read data (one cycle after access)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AWIDTH       = 12,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [31:0]       I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [3:0]        D_BE,
  input  logic [31:0]       D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [31:0]       D_RDATA,
  output logic              M_CSN,
  output logic              M_WEN,
  output logic [3:0]        M_BE,
  output logic [AWIDTH-1:0] M_ADDR,
  output logic [31:0]       M_DI,
  input  logic [31:0]       M_DOUT
);

  logic        force_i;
  logic        i_gnt;
  logic        d_gnt;
  resp_owner_e owner_q;
  resp_owner_e owner_d;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  // Only the word-address bits reach the SRAM; the rest are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_ADDR[31:AWIDTH+2], I_ADDR[1:0],
                              D_ADDR[31:AWIDTH+2], D_ADDR[1:0]};

  // D normally wins a contested cycle; the fairness counter hands the port
  // to I after MAX_D_STREAK contested D wins in a row.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (D_REQ && !(I_REQ && force_i)) begin
      d_gnt = 1'b1;
    end else if (I_REQ) begin
      i_gnt = 1'b1;
    end
  end

  assign I_GNT = i_gnt;
  assign D_GNT = d_gnt;

  arb_fairness_ctr #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_fairness (
    .clk_i             (CLK),
    .rst_i             (RST),
    .i_req_i           (I_REQ),
    .i_gnt_i           (i_gnt),
    .d_contested_gnt_i (d_gnt && I_REQ),
    .force_i_o         (force_i)
  );

  // SRAM strobe mux; everything is driven to a fixed idle pattern when no
  // one is granted so the array sees no spurious toggling.
  always_comb begin
    M_CSN  = CSN_IDLE;
    M_WEN  = WEN_READ;
    M_BE   = 4'b0000;
    M_ADDR = '0;
    M_DI   = 32'h0;
    if (i_gnt) begin
      M_CSN  = ~CSN_IDLE;
      M_ADDR = I_ADDR[AWIDTH+1:2];
    end else if (d_gnt) begin
      M_CSN  = ~CSN_IDLE;
      M_WEN  = ~D_WE;
      M_BE   = D_WE ? D_BE : 4'b0000;
      M_ADDR = D_ADDR[AWIDTH+1:2];
      M_DI   = D_WDATA;
    end
  end

  // Writes return nothing, so only reads claim the response slot.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt) begin
      owner_d = OWN_I;
    end else if (d_gnt && !D_WE) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign I_RVALID = (owner_q == OWN_I);
  assign D_RVALID = (owner_q == OWN_D);

  // The owner sees M_DOUT directly; the other side keeps showing the last
  // word it was handed, captured at the end of its response cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      if (owner_q == OWN_I) begin
        i_rdata_q <= M_DOUT;
      end
      if (owner_q == OWN_D) begin
        d_rdata_q <= M_DOUT;
      end
    end
  end

  assign I_RDATA = I_RVALID ? M_DOUT : i_rdata_q;
  assign D_RDATA = D_RVALID ? M_DOUT : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AWIDTH = 12;

  logic              CLK;
  logic              RST;
  logic              I_REQ;
  logic [31:0]       I_ADDR;
  logic              I_GNT;
  logic              I_RVALID;
  logic [31:0]       I_RDATA;
  logic              D_REQ;
  logic              D_WE;
  logic [3:0]        D_BE;
  logic [31:0]       D_ADDR;
  logic [31:0]       D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic [31:0]       D_RDATA;
  logic              M_CSN;
  logic              M_WEN;
  logic [3:0]        M_BE;
  logic [AWIDTH-1:0] M_ADDR;
  logic [31:0]       M_DI;
  logic [31:0]       M_DOUT;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];

  mem_port_arbiter #(.AWIDTH(AWIDTH), .MAX_D_STREAK(4)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT),
    .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA), .D_GNT(D_GNT),
    .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_BE(M_BE), .M_ADDR(M_ADDR),
    .M_DI(M_DI), .M_DOUT(M_DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural single-port SRAM, read data one cycle after the access.
  logic [31:0] mem [0:(1<<AWIDTH)-1];
  always @(posedge CLK) begin
    if (!M_CSN) begin
      if (!M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (M_BE[b]) mem[M_ADDR][8*b +: 8] <= M_DI[8*b +: 8];
      end else begin
        M_DOUT <= mem[M_ADDR];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: every response the DUT presents must match the next queued word.
  always @(negedge CLK) begin
    if (I_RVALID) begin
      if (exp_i_q.size() == 0) begin
        total++; bad++;
        $display("FAIL i_resp_unexpected: got=%h want=none", I_RDATA);
      end else begin
        chk("i_resp", I_RDATA, exp_i_q.pop_front());
      end
    end
    if (D_RVALID) begin
      if (exp_d_q.size() == 0) begin
        total++; bad++;
        $display("FAIL d_resp_unexpected: got=%h want=none", D_RDATA);
      end else begin
        chk("d_resp", D_RDATA, exp_d_q.pop_front());
      end
    end
  end

  task automatic set_i(input logic r, input logic [31:0] a);
    I_REQ = r; I_ADDR = a;
  endtask

  task automatic set_d(input logic r, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
    D_REQ = r; D_WE = we; D_BE = be; D_ADDR = a; D_WDATA = wd;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // 1 = I wins, 0 = D wins, with both requesting continuously.
  logic streak_pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    for (int k = 0; k < (1 << AWIDTH); k++) mem[k] = 32'h0;
    mem[1]  = 32'h0BAD_F00D;
    mem[4]  = 32'hDEAD_BEEF;
    mem[5]  = 32'h0000_5005;
    mem[8]  = 32'hAAAA_BBBB;
    mem[9]  = 32'h55AA_33CC;
    mem[16] = 32'h1111_0000;
    mem[17] = 32'h2222_0001;
    M_DOUT = 32'h0;

    RST = 1'b1;
    set_i(0, 32'h0);
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    #2;
    chk("rst_i_rvalid", I_RVALID, 0);
    chk("rst_d_rvalid", D_RVALID, 0);
    chk("rst_i_rdata", I_RDATA, 0);
    chk("rst_d_rdata", D_RDATA, 0);
    chk("rst_csn", M_CSN, 1);
    chk("rst_wen", M_WEN, 1);
    chk("rst_be", M_BE, 0);
    next_cycle();
    next_cycle();
    RST = 1'b0;
    next_cycle();

    // Single fetch
    set_i(1, 32'h0000_0010);
    #1;
    chk("f_i_gnt", I_GNT, 1);
    chk("f_d_gnt", D_GNT, 0);
    chk("f_csn", M_CSN, 0);
    chk("f_wen", M_WEN, 1);
    chk("f_be", M_BE, 0);
    chk("f_addr", M_ADDR, 4);
    exp_i_q.push_back(32'hDEAD_BEEF);
    next_cycle();
    set_i(0, 32'h0);
    #1;
    chk("f_rvalid", I_RVALID, 1);
    chk("idle_csn", M_CSN, 1);
    chk("idle_addr", M_ADDR, 0);
    next_cycle();

    // Byte-masked write then read-back
    set_d(1, 1, 4'b0011, 32'h0000_0020, 32'h1234_5678);
    #1;
    chk("w_d_gnt", D_GNT, 1);
    chk("w_wen", M_WEN, 0);
    chk("w_be", M_BE, 4'b0011);
    chk("w_addr", M_ADDR, 8);
    chk("w_di", M_DI, 32'h1234_5678);
    next_cycle();
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("w_no_rvalid", D_RVALID, 0);
    next_cycle();
    set_d(1, 0, 4'hF, 32'h0000_0020, 32'h0);
    #1;
    chk("r_wen", M_WEN, 1);
    chk("r_be", M_BE, 0);
    exp_d_q.push_back(32'hAAAA_5678);
    next_cycle();
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    next_cycle();

    // Contention: D,D,D,D,I repeating
    set_i(1, 32'h0000_0040);
    set_d(1, 0, 4'hF, 32'h0000_0044, 32'h0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("s_i_gnt", I_GNT, streak_pat[k]);
      chk("s_d_gnt", D_GNT, !streak_pat[k]);
      if (streak_pat[k]) exp_i_q.push_back(32'h1111_0000);
      else               exp_d_q.push_back(32'h2222_0001);
      @(posedge CLK);
      #1;
    end
    set_i(0, 32'h0);
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    next_cycle();

    // Alternating I, D, I reads
    set_i(1, 32'h0000_0010);
    #1;
    chk("a_i_gnt", I_GNT, 1);
    exp_i_q.push_back(32'hDEAD_BEEF);
    next_cycle();
    set_i(0, 32'h0);
    set_d(1, 0, 4'hF, 32'h0000_0024, 32'h0);
    #1;
    chk("a_d_gnt", D_GNT, 1);
    chk("a_d_addr", M_ADDR, 9);
    exp_d_q.push_back(32'h55AA_33CC);
    next_cycle();
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    set_i(1, 32'h0000_0014);
    #1;
    chk("a_i2_addr", M_ADDR, 5);
    exp_i_q.push_back(32'h0000_5005);
    next_cycle();
    set_i(0, 32'h0);
    #1;
    chk("a_d_hold", D_RDATA, 32'h55AA_33CC);
    next_cycle();

    // Upper address bits ignored
    set_d(1, 0, 4'hF, 32'hFFFF_C004, 32'h0);
    #1;
    chk("hi_addr", M_ADDR, 1);
    exp_d_q.push_back(32'h0BAD_F00D);
    next_cycle();
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    next_cycle();

    // Reset right after a fetch grant drops the response
    set_i(1, 32'h0000_0010);
    #1;
    chk("rr_i_gnt", I_GNT, 1);
    next_cycle();
    set_i(0, 32'h0);
    RST = 1'b1;
    #1;
    chk("rr_i_rvalid", I_RVALID, 0);
    chk("rr_i_rdata", I_RDATA, 0);
    next_cycle();
    RST = 1'b0;
    #1;
    chk("rr_csn", M_CSN, 1);
    chk("rr_i_rvalid2", I_RVALID, 0);
    next_cycle();
    #1;
    chk("rr_csn2", M_CSN, 1);
    chk("rr_i_rvalid3", I_RVALID, 0);
    next_cycle();
    next_cycle();

    chk("i_queue_empty", exp_i_q.size(), 0);
    chk("d_queue_empty", exp_d_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
